// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory loader: controller states, depth default
// and the word-index to byte-address helper.
package mem_loader_pkg;

  // Default number of 32-bit words in the target memory.
  localparam int DEPTH_DEFAULT = 64;

  // Controller states, in load order.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECV   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_CSUM   = 3'd3,
    ST_VERIFY = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Word index to word-aligned byte address (low two bits always zero).
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Handshake and memory bus of the loader: byte stream in, control in,
// memory write/read port and status out.
interface mem_loader_if #(
  parameter int CW = 7
);
  logic          start;
  logic [CW-1:0] count;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [31:0]   a;
  logic [31:0]   wd;
  logic [31:0]   rd;
  logic          cpu_hold;
  logic          done;
  logic          err;

  // Environment side: issues loads, feeds bytes, models the memory.
  modport master (
    output start, count, in_valid, in_data, rd,
    input  in_ready, we, a, wd, cpu_hold, done, err
  );

  // Loader side.
  modport slave (
    input  start, count, in_valid, in_data, rd,
    output in_ready, we, a, wd, cpu_hold, done, err
  );
endinterface

// File: rtl/mem_loader_byte_packer.sv
// Purpose: assembles four accepted bytes into a little-endian 32-bit word.
// Latency: word is presented combinationally together with the 4th byte.
// Backpressure: none of its own; only counts bytes the owner says were accepted.
module mem_loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_vld,
  input  logic [7:0]  i_data,
  output logic        o_last,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [23:0] r_lo;

  // Byte counter plus storage for the three low byte lanes; the top lane is
  // taken straight from the bus on the completing byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 2'd0;
      r_lo  <= 24'd0;
    end else if (i_clr) begin
      r_cnt <= 2'd0;
    end else if (i_vld) begin
      r_cnt <= r_cnt + 2'd1;
      case (r_cnt)
        2'd0:    r_lo[7:0]   <= i_data;
        2'd1:    r_lo[15:8]  <= i_data;
        2'd2:    r_lo[23:16] <= i_data;
        default: ;
      endcase
    end
  end

  assign o_last = (r_cnt == 2'd3);
  assign o_word = {i_data, r_lo};

endmodule

// File: rtl/mem_loader.sv
// Purpose: loads a checksummed little-endian byte stream into word memory,
// verifies it by reading back, and releases the CPU hold on success.
// Latency/backpressure: one WRITE cycle per word with in_ready low, count read cycles to verify.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_loader_if.slave  bus
);

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_idx;
  logic [31:0]   r_sum;
  logic [31:0]   r_csum;
  logic          r_in_ready;
  logic          r_we;
  logic [31:0]   r_a;
  logic [31:0]   r_wd;
  logic          r_done;
  logic          r_err;
  logic          r_cpu_hold;

  logic          w_xfer;
  logic          w_last;
  logic [31:0]   w_word;
  logic          w_count_ok;
  logic          w_can_start;
  logic          w_start_ok;
  logic          w_idx_last;
  logic [31:0]   w_sum_next;
  logic          w_sum_bad;

  assign w_xfer      = bus.in_valid & r_in_ready;
  assign w_count_ok  = (bus.count != '0) && (bus.count <= CW'(DEPTH));
  assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start_ok  = w_can_start && bus.start && w_count_ok;
  assign w_idx_last  = (r_idx == r_count - CW'(1));
  assign w_sum_next  = r_sum + bus.rd;
  assign w_sum_bad   = (w_sum_next != r_csum);

  mem_loader_byte_packer byte_packer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_start_ok),
    .i_vld  (w_xfer),
    .i_data (bus.in_data),
    .o_last (w_last),
    .o_word (w_word)
  );

  // Load controller; every bus output is registered alongside the state so
  // outputs change exactly when the state does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_csum     <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_a        <= '0;
      r_wd       <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_cpu_hold <= 1'b1;
            if (w_count_ok) begin
              r_state    <= ST_RECV;
              r_count    <= bus.count;
              r_idx      <= '0;
              r_sum      <= '0;
              r_err      <= 1'b0;
              r_done     <= 1'b0;
              r_in_ready <= 1'b1;
            end else begin
              // Bad length: fail straight away without touching memory.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end

        ST_RECV: begin
          if (w_xfer && w_last) begin
            r_state    <= ST_WRITE;
            r_in_ready <= 1'b0;
            r_we       <= 1'b1;
            r_a        <= word_addr(32'(r_idx));
            r_wd       <= w_word;
          end
        end

        ST_WRITE: begin
          r_we       <= 1'b0;
          r_a        <= '0;
          r_wd       <= '0;
          r_idx      <= r_idx + CW'(1);
          r_in_ready <= 1'b1;
          r_state    <= w_idx_last ? ST_CSUM : ST_RECV;
        end

        ST_CSUM: begin
          if (w_xfer && w_last) begin
            r_state    <= ST_VERIFY;
            r_csum     <= w_word;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_a        <= '0;
          end
        end

        ST_VERIFY: begin
          // Read back one word per cycle and accumulate it modulo 2^32.
          r_sum <= w_sum_next;
          if (w_idx_last) begin
            r_state    <= ST_DONE;
            r_a        <= '0;
            r_done     <= 1'b1;
            r_err      <= w_sum_bad;
            r_cpu_hold <= w_sum_bad;
          end else begin
            r_idx <= r_idx + CW'(1);
            r_a   <= word_addr(32'(r_idx + CW'(1)));
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.we       = r_we;
  assign bus.a        = r_a;
  assign bus.wd       = r_wd;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.cpu_hold = r_cpu_hold;

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter DEPTH, default 64, SHALL give the number of 32-bit words in the target memory.
REQ-002 Parameter CW, default 7, SHALL give the width of count and equal $clog2(DEPTH)+1.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  in  1  SHALL be a one-cycle request to begin a load.
REQ-006 count  in  CW  SHALL give the number of words to load, sampled when start is accepted.
REQ-007 in_valid  in  1  SHALL mark in_data as a valid byte.
REQ-008 in_data  in  8  SHALL carry the byte stream.
REQ-009 in_ready  out  1  SHALL mark that the block accepts a byte this cycle.
REQ-010 we  out  1  SHALL be the memory write enable.
REQ-011 a  out  32  SHALL be the byte address to memory; always word aligned, a[1:0]=0.
REQ-012 wd  out  32  SHALL be the memory write data.
REQ-013 rd  in  32  SHALL be the combinational memory read data for address a.
REQ-014 cpu_hold  out  1  SHALL hold the processor in reset while high.
REQ-015 done  out  1  SHALL flag a completed load.
REQ-016 err  out  1  SHALL flag a failed load; valid while done=1.

Function
REQ-017 Byte transfer SHALL occur only on a cycle where in_valid=1 and in_ready=1.
REQ-018 States SHALL be IDLE, RECV, WRITE, CSUM, VERIFY, DONE.
REQ-019 IDLE/DONE: start=1 with 1<=count<=DEPTH SHALL go to RECV, clear word index, byte count, sum and err.
REQ-020 IDLE/DONE: start=1 with count=0 or count>DEPTH SHALL go to DONE with err=1 and no memory write.
REQ-021 start SHALL be ignored in RECV, WRITE, CSUM and VERIFY.
REQ-022 RECV/CSUM: in_ready=1; bytes SHALL assemble little-endian (first byte into bits [7:0]).
REQ-023 RECV: after the 4th accepted byte the next state SHALL be WRITE.
REQ-024 WRITE: lasts exactly one cycle; we=1, a=index*4, wd=assembled word, in_ready=0.
REQ-025 WRITE: index SHALL increment; next state is CSUM if index=count-1, else RECV.
REQ-026 CSUM: after 4 accepted bytes the next state SHALL be VERIFY with the index cleared.
REQ-027 VERIFY: one word per cycle, a=index*4, sum+=rd modulo 2^32, in_ready=0, we=0.
REQ-028 VERIFY: after count cycles next state SHALL be DONE; err=1 if sum differs from received checksum.
REQ-029 Outside WRITE and VERIFY, a=0 and wd=0; outside WRITE, we=0.
REQ-030 done SHALL be 1 only in DONE; cpu_hold SHALL be 0 only in DONE with err=0.
REQ-031 An idle gap (in_valid=0) of any length SHALL stall RECV/CSUM without losing state.

Reset
REQ-032 reset SHALL force IDLE asynchronously; in_ready=0, we=0, a=0, wd=0, done=0, err=0, cpu_hold=1.
REQ-033 Reset mid-load SHALL abandon the load; words already written are left as written.

Structure
REQ-034 A shared package SHALL hold the state enum and the DEPTH default.
REQ-035 One sub-module, byte_packer, SHALL hold the 4-byte little-endian assembler with its byte counter.

Verification
REQ-036 count=2, bytes 3F 02 40 E3 02 10 81 E0, checksum 41 12 C1 C3 -> writes (0,E340023F),(4,E0811002); done=1, err=0, cpu_hold=0.
REQ-037 Same stream but checksum 00 00 00 00 -> done=1, err=1, cpu_hold=1.
REQ-038 start with count=0 and with count=65 -> DONE next cycle, err=1, we never high.
REQ-039 in_valid toggled 1/0 every cycle during REQ-036 -> identical writes and result.
REQ-040 reset asserted after the 6th byte of REQ-036 -> IDLE immediately, only (0,E340023F) written, cpu_hold=1.
REQ-041 count=64 full load, words = index value -> 64 writes at a=0..252, last write in state WRITE, then err=0.
